ppm_slot_demod: RTL and testbench

PPM_SLOT_DEMOD -- requirements
Module: ppm_slot_demod

---
 rtl/ppm_slot_demod.sv | 164 ++++++++++++++++
 tb/tb_ppm_slot_demod.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_slot_demod.sv
// Frames L-slot PPM symbols after sync, resolves each to a slot index or erasure, queues it in a FWFT FIFO.
// Latency: the decision enters the FIFO on the edge that ends slot L-1, so obs_valid can rise in the following cycle.
// Backpressure: obs_valid/obs_ready handshake; a symbol arriving at a full FIFO with no pop is dropped and counted in ovf_cnt.
module ppm_slot_demod #(
    parameter int L           = 1024,
    parameter int GUARD_SLOTS = 256,
    parameter bit MULTI_ERASE = 1'b1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk_12mhz,
    input  logic                 rst_n,
    input  logic                 sync_in,
    input  logic                 det_in,
    input  logic                 enable,
    output logic [$clog2(L):0]   obs_out,
    output logic                 obs_valid,
    input  logic                 obs_ready,
    output logic [15:0]          sym_cnt,
    output logic [15:0]          era_cnt,
    output logic [15:0]          ovf_cnt,
    output logic                 busy
);
    localparam int SW = $clog2(L);
    localparam int CW = (SW > 10) ? SW : 10;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_SLOT  = CW'(L - 1);
    localparam logic [CW-1:0] LAST_GUARD = CW'(GUARD_SLOTS - 1);
    localparam logic [SW:0]   ERASE      = (SW + 1)'(L);

    typedef enum logic [1:0] {IDLE, DATA, GUARD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    hit_q, hit_d;
    logic [SW-1:0] lat_q, lat_d;
    logic          busy_q, busy_d;
    logic [SW:0]   mem_q [FIFO_DEPTH];
    logic [SW:0]   mem_d [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]   sym_q, sym_d, era_q, era_d, ovf_q, ovf_d;

    logic          push, pop, wr, empty, full;
    logic [SW:0]   push_dat;
    logic [1:0]    hit_fin;
    logic [SW-1:0] win_slot;

    // Framing FSM; the decision folds in the det_in of slot L-1 itself.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        lat_d    = lat_q;
        push     = 1'b0;
        push_dat = ERASE;
        hit_fin  = hit_q;
        if (det_in && hit_q != 2'd2) hit_fin = hit_q + 2'd1;
        win_slot = (hit_q == 2'd0) ? cnt_q[SW-1:0] : lat_q;

        case (state_q)
            IDLE: begin
                if (sync_in && enable) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    hit_d   = '0;
                    lat_d   = '0;
                end
            end
            DATA: begin
                if (sync_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    hit_d   = '0;
                    lat_d   = '0;
                end else begin
                    hit_d = hit_fin;
                    if (det_in && hit_q == 2'd0) lat_d = cnt_q[SW-1:0];
                    if (cnt_q == LAST_SLOT) begin
                        push = 1'b1;
                        if (hit_fin == 2'd1 || (hit_fin == 2'd2 && !MULTI_ERASE))
                            push_dat = {1'b0, win_slot};
                        cnt_d = '0;
                        hit_d = '0;
                        lat_d = '0;
                        state_d = (GUARD_SLOTS == 0 || !enable) ? IDLE : GUARD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            GUARD: begin
                if (sync_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_GUARD) begin
                    cnt_d   = '0;
                    state_d = enable ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        obs_valid = !empty;
        obs_out   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
        pop       = obs_valid && obs_ready;
        wr        = push && (!full || pop);

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        sym_d  = sym_q;
        era_d  = era_q;
        ovf_d  = ovf_q;
        if (wr) begin
            mem_d[wptr_q[AW-1:0]] = push_dat;
            wptr_d = wptr_q + (AW + 1)'(1);
            sym_d  = sym_q + 16'd1;
            if (push_dat == ERASE) era_d = era_q + 16'd1;
        end else if (push && ovf_q != 16'hFFFF) begin
            ovf_d = ovf_q + 16'd1;
        end
        if (pop) rptr_d = rptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hit_q   <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            sym_q   <= '0;
            era_q   <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            sym_q   <= sym_d;
            era_q   <= era_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign sym_cnt = sym_q;
    assign era_cnt = era_q;
    assign ovf_cnt = ovf_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_ppm_slot_demod.sv
// Bench for ppm_slot_demod: directed vector table, multi-cycle corner sequences and a randomized run
// against a symbol-level model (decision rule + bounded observation queue + counters).
module tb_ppm_slot_demod;
    localparam int L     = 1024;
    localparam int G     = 256;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, sync_in, det_in, enable, obs_ready;
    logic [10:0] obs_out, obs_out_b;
    logic        obs_valid, obs_valid_b, busy, busy_b;
    logic [15:0] sym_cnt, era_cnt, ovf_cnt, sym_cnt_b, era_cnt_b, ovf_cnt_b;

    always #5 clk = ~clk;

    ppm_slot_demod dut (
        .clk_12mhz(clk), .rst_n(rst_n), .sync_in(sync_in), .det_in(det_in), .enable(enable),
        .obs_out(obs_out), .obs_valid(obs_valid), .obs_ready(obs_ready),
        .sym_cnt(sym_cnt), .era_cnt(era_cnt), .ovf_cnt(ovf_cnt), .busy(busy)
    );

    ppm_slot_demod #(.MULTI_ERASE(1'b0)) dut_b (
        .clk_12mhz(clk), .rst_n(rst_n), .sync_in(sync_in), .det_in(det_in), .enable(enable),
        .obs_out(obs_out_b), .obs_valid(obs_valid_b), .obs_ready(obs_ready),
        .sym_cnt(sym_cnt_b), .era_cnt(era_cnt_b), .ovf_cnt(ovf_cnt_b), .busy(busy_b)
    );

    int          total = 0;
    int          bad   = 0;
    bit          hitmap [0:L-1];
    logic [10:0] mq [$];
    int          m_sym, m_era, m_ovf;
    bit          pend_push = 1'b0;
    logic [10:0] pend_val;
    bit          rnd_rdy = 1'b0;

    typedef struct {
        int h0;
        int h1;
        int exp_a;
        int exp_b;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] decide();
        int n = 0;
        int first = -1;
        for (int s = 0; s < L; s++)
            if (hitmap[s]) begin
                if (first < 0) first = s;
                n++;
            end
        if (n == 0 || n > 1) return 11'd1024;
        return 11'(first);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_sym = 0;
        m_era = 0;
        m_ovf = 0;
    endtask

    // One clock: model pop/push bookkeeping for the upcoming edge, then advance.
    task automatic step();
        bit pop, acc;
        if (rnd_rdy) obs_ready = 1'($urandom_range(0, 1));
        pop = (mq.size() > 0) && obs_ready;
        if (pop) begin
            chk("pop_valid", int'(obs_valid), 1);
            chk("pop_data", int'(obs_out), int'(mq[0]));
        end
        acc = 1'b0;
        if (pend_push) begin
            if (mq.size() < DEPTH || pop) begin
                acc   = 1'b1;
                m_sym = (m_sym + 1) % 65536;
                if (pend_val == 11'd1024) m_era = (m_era + 1) % 65536;
            end else if (m_ovf < 65535) begin
                m_ovf++;
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(pend_val);
        pend_push = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_hits(input int a, input int b);
        foreach (hitmap[i]) hitmap[i] = 1'b0;
        if (a >= 0) hitmap[a] = 1'b1;
        if (b >= 0) hitmap[b] = 1'b1;
    endtask

    task automatic start_sync();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
    endtask

    task automatic data_phase(input int abort_at, input bit rdy_pulse);
        for (int s = 0; s < L; s++) begin
            det_in = hitmap[s];
            if (s == abort_at) begin
                sync_in = 1'b1;
                step();
                sync_in = 1'b0;
                det_in  = 1'b0;
                return;
            end
            if (s == L - 1) begin
                pend_push = 1'b1;
                pend_val  = decide();
                if (rdy_pulse) obs_ready = 1'b1;
            end
            step();
        end
        det_in = 1'b0;
        if (rdy_pulse) obs_ready = 1'b0;
    endtask

    task automatic guard_phase(input bit noise);
        for (int g = 0; g < G; g++) begin
            det_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        det_in = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_era;
        rst_n = 1'b0; sync_in = 1'b0; det_in = 1'b0; enable = 1'b0; obs_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(obs_valid), 0);
        chk("rst_obs", int'(obs_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sym", int'(sym_cnt), 0);
        chk("rst_era", int'(era_cnt), 0);
        chk("rst_ovf", int'(ovf_cnt), 0);
        rst_n = 1'b1;
        step();

        // Sync while disabled must not start a symbol.
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        step();
        chk("idle_sync_dis", int'(busy), 0);

        vecs[0] = '{517, -1, 517, 517};
        vecs[1] = '{-1, -1, 1024, 1024};
        vecs[2] = '{3, 900, 1024, 3};
        vecs[3] = '{0, -1, 0, 0};
        vecs[4] = '{1023, -1, 1023, 1023};
        vecs[5] = '{0, 1023, 1024, 0};
        vecs[6] = '{5, 6, 1024, 5};
        exp_era = 0;
        for (int i = 0; i < 7; i++) begin
            set_hits(vecs[i].h0, vecs[i].h1);
            enable = 1'b1;
            obs_ready = 1'b1;
            start_sync();
            data_phase(-1, 1'b0);
            chk("vec_valid", int'(obs_valid), 1);
            chk("vec_obs_a", int'(obs_out), vecs[i].exp_a);
            chk("vec_obs_b", int'(obs_out_b), vecs[i].exp_b);
            chk("vec_busy", int'(busy), 1);
            if (vecs[i].exp_a == 1024) exp_era++;
            enable = 1'b0;
            step();
            chk("vec_one_cycle", int'(obs_valid), 0);
            guard_phase(1'b1);
            chk("vec_idle", int'(busy), 0);
            chk("vec_sym", int'(sym_cnt), i + 1);
            chk("vec_era", int'(era_cnt), exp_era);
            chk("vec_guard_quiet", int'(obs_valid), 0);
        end

        // Back-to-back free-running symbols into a stalled consumer.
        obs_ready = 1'b0;
        enable = 1'b1;
        start_sync();
        for (int i = 0; i < 7; i++) begin
            set_hits(i, -1);
            data_phase(-1, i == 6);
            if (i == 5) begin
                chk("full_valid", int'(obs_valid), 1);
                chk("full_hold", int'(obs_out), 0);
                chk("full_ovf", int'(ovf_cnt), 2);
            end
            if (i == 6) enable = 1'b0;
            guard_phase(1'b0);
        end
        chk("ovf_after_pp", int'(ovf_cnt), 2);
        chk("head_after_pp", int'(obs_out), 1);
        chk("sym_after_pp", int'(sym_cnt), m_sym);
        obs_ready = 1'b1;
        repeat (6) step();
        chk("drained", int'(obs_valid), 0);

        // Sync mid-symbol aborts it; the restarted symbol decodes from slot 0.
        enable = 1'b1;
        set_hits(100, -1);
        start_sync();
        data_phase(300, 1'b0);
        set_hits(42, -1);
        data_phase(-1, 1'b0);
        chk("abort_obs", int'(obs_out), 42);
        chk("abort_sym", int'(sym_cnt), m_sym);
        enable = 1'b0;
        guard_phase(1'b0);
        chk("abort_quiet", int'(obs_valid), 0);

        // Reset in the middle of a symbol with two entries queued.
        obs_ready = 1'b0;
        enable = 1'b1;
        set_hits(10, -1);
        start_sync();
        data_phase(-1, 1'b0);
        guard_phase(1'b0);
        set_hits(20, -1);
        data_phase(-1, 1'b0);
        guard_phase(1'b0);
        for (int s = 0; s < 700; s++) step();
        chk("pre_rst_valid", int'(obs_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(obs_valid), 0);
        chk("mid_rst_sym", int'(sym_cnt), 0);
        chk("mid_rst_era", int'(era_cnt), 0);
        chk("mid_rst_ovf", int'(ovf_cnt), 0);
        chk("mid_rst_busy", int'(busy), 0);
        model_reset();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            det_in = 1'($urandom_range(0, 1));
            step();
        end
        det_in = 1'b0;
        chk("post_rst_idle", int'(busy), 0);
        chk("post_rst_valid", int'(obs_valid), 0);
        obs_ready = 1'b1;
        set_hits(33, -1);
        start_sync();
        data_phase(-1, 1'b0);
        chk("post_rst_obs", int'(obs_out), 33);
        enable = 1'b0;
        guard_phase(1'b0);

        // Randomized hits and consumer stalls against the model.
        enable = 1'b1;
        rnd_rdy = 1'b1;
        start_sync();
        for (int k = 0; k < 8; k++) begin
            int n;
            foreach (hitmap[i]) hitmap[i] = 1'b0;
            n = int'($urandom_range(0, 3));
            for (int h = 0; h < n; h++) hitmap[$urandom_range(0, L - 1)] = 1'b1;
            data_phase(-1, 1'b0);
            if (k == 7) enable = 1'b0;
            guard_phase(1'b0);
        end
        rnd_rdy = 1'b0;
        obs_ready = 1'b1;
        repeat (6) step();
        chk("rnd_drained", int'(obs_valid), 0);
        chk("rnd_sym", int'(sym_cnt), m_sym);
        chk("rnd_era", int'(era_cnt), m_era);
        chk("rnd_ovf", int'(ovf_cnt), m_ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
